// File: rtl/usb_ep0_ctrl_sequencer.sv
// Endpoint-0 control-transfer sequencer: captures SETUP packets, decodes the request,
// streams IN data from a descriptor ROM, swallows OUT data and runs the status stage.
module usb_ep0_ctrl_sequencer #(
  parameter int MAX_PKT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        usb_rst,
  input  logic        transaction_active,
  input  logic        setup,
  input  logic        direction_in,
  input  logic        success,
  input  logic        data_strobe,
  input  logic [3:0]  endpoint,
  input  logic [7:0]  data_out,
  output logic [7:0]  data_in,
  output logic        data_in_valid,
  output logic        data_toggle,
  output logic [1:0]  handshake,
  output logic [6:0]  usb_address,
  output logic [7:0]  rom_addr,
  input  logic [7:0]  rom_data,
  output logic        req_valid,
  output logic [7:0]  bm_request_type,
  output logic [7:0]  b_request,
  output logic [15:0] w_value,
  output logic [15:0] w_index,
  output logic [15:0] w_length,
  input  logic [7:0]  resp_offset,
  input  logic [7:0]  resp_len,
  input  logic        resp_stall,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETUP_RX = 3'd1,
    S_DECODE   = 3'd2,
    S_DATA_IN  = 3'd3,
    S_DATA_OUT = 3'd4,
    S_STATUS   = 3'd5,
    S_STALL    = 3'd6
  } state_t;

  localparam logic [6:0] PKT_MAX = 7'(MAX_PKT);

  state_t      state_q, state_d;
  logic        ta_q;
  logic        x_ep0_q, x_ep0_d, x_in_q, x_in_d, x_setup_q, x_setup_d;
  logic [3:0]  count_q, count_d;
  logic [63:0] setup_q, setup_d;
  logic        toggle_q, toggle_d;
  logic [6:0]  addr_q, addr_d;
  logic [15:0] sent_q, sent_d;
  logic [6:0]  pkt_q, pkt_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  off_q, off_d;
  logic        status_in_q, status_in_d;

  logic        any_rst, ep0, start, xend, end_ep0, set_addr;
  logic [15:0] pos;
  logic [7:0]  dec_len;

  assign any_rst  = rst | usb_rst;
  assign ep0      = (endpoint == 4'd0);
  assign start    = transaction_active & ~ta_q;
  assign xend     = ~transaction_active & ta_q;
  // Token attributes are latched at start because they may be gone by the falling edge.
  assign end_ep0  = xend & x_ep0_q & ~x_setup_q;
  assign pos      = sent_q + {9'd0, pkt_q};
  assign set_addr = (bm_request_type == 8'h00) && (b_request == 8'h05);

  assign bm_request_type = setup_q[7:0];
  assign b_request       = setup_q[15:8];
  assign w_value         = setup_q[31:16];
  assign w_index         = setup_q[47:32];
  assign w_length        = setup_q[63:48];
  assign dec_len         = (w_length < {8'd0, resp_len}) ? w_length[7:0] : resp_len;

  // data_in is offered while data_in_valid is high; the core takes the byte with
  // data_strobe, which advances to the next byte of the packet.
  assign data_in_valid = ~any_rst && (state_q == S_DATA_IN) && transaction_active && ep0 &&
                         direction_in && ~setup && (pos < {8'd0, len_q}) && (pkt_q < PKT_MAX);
  assign data_in       = data_in_valid ? rom_data : 8'h00;
  assign rom_addr      = (state_q == S_DATA_IN) ? (off_q + sent_q[7:0] + {1'b0, pkt_q}) : 8'h00;
  assign req_valid     = ~any_rst && (state_q == S_DECODE);
  assign handshake     = (~any_rst && (state_q == S_STALL)) ? 2'b11 : 2'b00;
  assign data_toggle   = toggle_q;
  assign usb_address   = addr_q;
  assign state_dbg     = state_q;

  always_comb begin
    state_d     = state_q;
    x_ep0_d     = x_ep0_q;
    x_in_d      = x_in_q;
    x_setup_d   = x_setup_q;
    count_d     = count_q;
    setup_d     = setup_q;
    toggle_d    = toggle_q;
    addr_d      = addr_q;
    sent_d      = sent_q;
    pkt_d       = pkt_q;
    len_d       = len_q;
    off_d       = off_q;
    status_in_d = status_in_q;
    if (start) begin
      x_ep0_d   = ep0;
      x_in_d    = direction_in;
      x_setup_d = setup;
    end
    if (start && ep0 && setup) begin
      state_d  = S_SETUP_RX;
      count_d  = 4'd0;
      toggle_d = 1'b0;
    end else begin
      case (state_q)
        S_SETUP_RX: begin
          if (transaction_active && ep0 && data_strobe && (count_q < 4'd8)) begin
            setup_d[{count_q[2:0], 3'b000} +: 8] = data_out;
            count_d = count_q + 4'd1;
          end
          if (xend && x_ep0_q) state_d = (success && count_q == 4'd8) ? S_DECODE : S_IDLE;
        end
        S_DECODE: begin
          toggle_d = 1'b1;
          len_d    = dec_len;
          off_d    = resp_offset;
          sent_d   = 16'd0;
          pkt_d    = 7'd0;
          if (resp_stall) begin
            state_d = S_STALL;
          end else if (bm_request_type[7] && dec_len != 8'd0) begin
            state_d = S_DATA_IN;
          end else if (!bm_request_type[7] && w_length != 16'd0) begin
            state_d = S_DATA_OUT;
          end else begin
            state_d     = S_STATUS;
            status_in_d = 1'b1;
          end
        end
        S_DATA_IN: begin
          if (start && ep0 && !direction_in) begin
            state_d     = S_STATUS;
            status_in_d = 1'b0;
            toggle_d    = 1'b1;
            pkt_d       = 7'd0;
          end else begin
            if (data_in_valid && data_strobe) pkt_d = pkt_q + 7'd1;
            if (end_ep0 && x_in_q) begin
              pkt_d = 7'd0;
              if (success) begin
                sent_d   = pos;
                toggle_d = ~toggle_q;
                if (pos == {8'd0, len_q} || pkt_q < PKT_MAX) begin
                  state_d     = S_STATUS;
                  status_in_d = 1'b0;
                  toggle_d    = 1'b1;
                end
              end
            end
          end
        end
        S_DATA_OUT: begin
          if (transaction_active && ep0 && !setup && !direction_in && data_strobe &&
              (pkt_q < PKT_MAX)) pkt_d = pkt_q + 7'd1;
          if (end_ep0 && !x_in_q) begin
            pkt_d = 7'd0;
            if (success) begin
              sent_d   = pos;
              toggle_d = ~toggle_q;
              if (pos >= w_length) begin
                state_d     = S_STATUS;
                status_in_d = 1'b1;
                toggle_d    = 1'b1;
              end
            end
          end
        end
        S_STATUS: begin
          // The address only changes once the host has acknowledged the status stage.
          if (end_ep0 && (x_in_q == status_in_q) && success) begin
            state_d = S_IDLE;
            if (set_addr) addr_d = w_value[6:0];
          end
        end
        S_IDLE, S_STALL: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (any_rst) begin
      state_q     <= S_IDLE;
      ta_q        <= 1'b0;
      x_ep0_q     <= 1'b0;
      x_in_q      <= 1'b0;
      x_setup_q   <= 1'b0;
      count_q     <= 4'd0;
      setup_q     <= 64'd0;
      toggle_q    <= 1'b0;
      addr_q      <= 7'd0;
      sent_q      <= 16'd0;
      pkt_q       <= 7'd0;
      len_q       <= 8'd0;
      off_q       <= 8'd0;
      status_in_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ta_q        <= transaction_active;
      x_ep0_q     <= x_ep0_d;
      x_in_q      <= x_in_d;
      x_setup_q   <= x_setup_d;
      count_q     <= count_d;
      setup_q     <= setup_d;
      toggle_q    <= toggle_d;
      addr_q      <= addr_d;
      sent_q      <= sent_d;
      pkt_q       <= pkt_d;
      len_q       <= len_d;
      off_q       <= off_d;
      status_in_q <= status_in_d;
    end
  end

endmodule

// File: tb/tb_usb_ep0_ctrl_sequencer.sv
// Directed bench for usb_ep0_ctrl_sequencer: control transfers, retries, stall,
// SET_ADDRESS timing and bus reset, with a combinational descriptor ROM stub.
module tb_usb_ep0_ctrl_sequencer;

  logic        clk, rst, usb_rst;
  logic        transaction_active, setup, direction_in, success, data_strobe;
  logic [3:0]  endpoint;
  logic [7:0]  data_out, rom_data, resp_offset, resp_len;
  logic        resp_stall;
  logic [7:0]  data_in, rom_addr, bm_request_type, b_request;
  logic        data_in_valid, data_toggle, req_valid;
  logic [1:0]  handshake;
  logic [6:0]  usb_address;
  logic [15:0] w_value, w_index, w_length;
  logic [2:0]  state_dbg;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_SETUP = 3'd1, ST_DECODE = 3'd2, ST_DIN = 3'd3,
                         ST_DOUT = 3'd4, ST_STATUS = 3'd5, ST_STALL = 3'd6;

  usb_ep0_ctrl_sequencer #(.MAX_PKT(8)) dut (
    .clk(clk), .rst(rst), .usb_rst(usb_rst),
    .transaction_active(transaction_active), .setup(setup), .direction_in(direction_in),
    .success(success), .data_strobe(data_strobe), .endpoint(endpoint), .data_out(data_out),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_toggle(data_toggle),
    .handshake(handshake), .usb_address(usb_address), .rom_addr(rom_addr), .rom_data(rom_data),
    .req_valid(req_valid), .bm_request_type(bm_request_type), .b_request(b_request),
    .w_value(w_value), .w_index(w_index), .w_length(w_length),
    .resp_offset(resp_offset), .resp_len(resp_len), .resp_stall(resp_stall),
    .state_dbg(state_dbg)
  );

  function automatic logic [7:0] rom_model(input logic [7:0] a);
    return a ^ 8'h5A;
  endfunction

  assign rom_data = rom_model(rom_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end of the test");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_setup(input logic [7:0] bm, input logic [7:0] breq, input logic [15:0] wv,
                          input logic [15:0] wi, input logic [15:0] wl, input logic [6:0] addr);
    logic [7:0] b [8];
    b = '{bm, breq, wv[7:0], wv[15:8], wi[7:0], wi[15:8], wl[7:0], wl[15:8]};
    endpoint = 4'd0; setup = 1'b1; direction_in = 1'b0; transaction_active = 1'b1;
    step(); #1;
    chk("setup_handshake", handshake, 2'b00);
    chk("setup_toggle", data_toggle, 1'b0);
    chk("setup_state", state_dbg, ST_SETUP);
    for (int i = 0; i < 8; i++) begin
      data_out = b[i]; data_strobe = 1'b1;
      step();
    end
    data_strobe = 1'b0; transaction_active = 1'b0; success = 1'b1;
    step();
    success = 1'b0; setup = 1'b0; #1;
    chk("decode_state", state_dbg, ST_DECODE);
    chk("decode_req_valid", req_valid, 1'b1);
    chk("decode_bm", bm_request_type, bm);
    chk("decode_breq", b_request, breq);
    chk("decode_wvalue", w_value, wv);
    chk("decode_windex", w_index, wi);
    chk("decode_wlength", w_length, wl);
    chk("decode_addr", usb_address, addr);
    step(); #1;
    chk("post_decode_req_valid", req_valid, 1'b0);
  endtask

  task automatic in_xact(input int nb, input logic tog, input logic [1:0] hs, input logic ok,
                         input logic [7:0] a0);
    logic [7:0] a;
    endpoint = 4'd0; setup = 1'b0; direction_in = 1'b1; transaction_active = 1'b1;
    step(); #1;
    chk("in_toggle", data_toggle, tog);
    chk("in_handshake", handshake, hs);
    for (int i = 0; i < nb; i++) begin
      a = a0 + 8'(i);
      chk("in_valid", data_in_valid, 1'b1);
      chk("in_rom_addr", rom_addr, a);
      chk("in_data", data_in, rom_model(a));
      data_strobe = 1'b1;
      step();
      data_strobe = 1'b0; #1;
    end
    chk("in_valid_after_last", data_in_valid, 1'b0);
    transaction_active = 1'b0; success = ok;
    step();
    success = 1'b0; direction_in = 1'b0;
  endtask

  task automatic out_xact(input int nb, input logic tog, input logic [1:0] hs, input logic ok);
    endpoint = 4'd0; setup = 1'b0; direction_in = 1'b0; transaction_active = 1'b1;
    step(); #1;
    chk("out_toggle", data_toggle, tog);
    chk("out_handshake", handshake, hs);
    chk("out_valid", data_in_valid, 1'b0);
    for (int i = 0; i < nb; i++) begin
      data_out = 8'($urandom_range(0, 255)); data_strobe = 1'b1;
      step();
    end
    data_strobe = 1'b0; transaction_active = 1'b0; success = ok;
    step();
    success = 1'b0;
  endtask

  initial begin
    rst = 1'b1; usb_rst = 1'b0; transaction_active = 1'b0; setup = 1'b0; direction_in = 1'b0;
    success = 1'b0; data_strobe = 1'b0; endpoint = 4'd0; data_out = 8'h00;
    resp_offset = 8'h00; resp_len = 8'h00; resp_stall = 1'b0;
    step(); step(); step(); #1;
    chk("rst_state", state_dbg, ST_IDLE);
    chk("rst_data_in", data_in, 8'h00);
    chk("rst_valid", data_in_valid, 1'b0);
    chk("rst_toggle", data_toggle, 1'b0);
    chk("rst_handshake", handshake, 2'b00);
    chk("rst_address", usb_address, 7'h00);
    chk("rst_req_valid", req_valid, 1'b0);
    chk("rst_rom_addr", rom_addr, 8'h00);
    chk("rst_wlength", w_length, 16'h0000);
    rst = 1'b0;
    step();

    // GET_DESCRIPTOR, 18 bytes: packets of 8, 8, 2 then OUT ZLP status
    resp_offset = 8'h20; resp_len = 8'd18;
    do_setup(8'h80, 8'h06, 16'h0100, 16'h0000, 16'd18, 7'h00);
    chk("gd_state_din", state_dbg, ST_DIN);
    in_xact(8, 1'b1, 2'b00, 1'b1, 8'h20);
    chk("gd_state_pkt1", state_dbg, ST_DIN);
    in_xact(8, 1'b0, 2'b00, 1'b1, 8'h28);
    chk("gd_state_pkt2", state_dbg, ST_DIN);
    in_xact(2, 1'b1, 2'b00, 1'b1, 8'h30);
    #1; chk("gd_state_status", state_dbg, ST_STATUS);
    out_xact(0, 1'b1, 2'b00, 1'b1);
    #1; chk("gd_state_idle", state_dbg, ST_IDLE);

    // SET_ADDRESS 0x12: address moves only after the IN ZLP succeeds
    do_setup(8'h00, 8'h05, 16'h0012, 16'h0000, 16'h0000, 7'h00);
    chk("sa_state_status", state_dbg, ST_STATUS);
    chk("sa_addr_after_decode", usb_address, 7'h00);
    endpoint = 4'd0; direction_in = 1'b1; transaction_active = 1'b1;
    step(); #1;
    chk("sa_zlp_valid", data_in_valid, 1'b0);
    chk("sa_zlp_toggle", data_toggle, 1'b1);
    transaction_active = 1'b0; success = 1'b1; #1;
    chk("sa_addr_in_end_cycle", usb_address, 7'h00);
    step();
    success = 1'b0; direction_in = 1'b0; #1;
    chk("sa_addr_applied", usb_address, 7'h12);
    chk("sa_state_idle", state_dbg, ST_IDLE);

    // wLength 64 clipped to resp_len 18
    resp_offset = 8'h40; resp_len = 8'd18;
    do_setup(8'h80, 8'h06, 16'h0200, 16'h0000, 16'd64, 7'h12);
    in_xact(8, 1'b1, 2'b00, 1'b1, 8'h40);
    in_xact(8, 1'b0, 2'b00, 1'b1, 8'h48);
    in_xact(2, 1'b1, 2'b00, 1'b1, 8'h50);
    #1; chk("clip_state_status", state_dbg, ST_STATUS);
    out_xact(0, 1'b1, 2'b00, 1'b1);
    #1; chk("clip_state_idle", state_dbg, ST_IDLE);

    // wLength 5 below resp_len 40; first IN fails and is retried unchanged
    resp_offset = 8'h10; resp_len = 8'd40;
    do_setup(8'h80, 8'h06, 16'h0300, 16'h0409, 16'd5, 7'h12);
    in_xact(5, 1'b1, 2'b00, 1'b0, 8'h10);
    #1; chk("retry_state_din", state_dbg, ST_DIN);
    in_xact(5, 1'b1, 2'b00, 1'b1, 8'h10);
    #1; chk("retry_state_status", state_dbg, ST_STATUS);
    out_xact(0, 1'b1, 2'b00, 1'b1);
    #1; chk("retry_state_idle", state_dbg, ST_IDLE);

    // Early status: OUT token arrives after the first IN packet
    resp_offset = 8'h60; resp_len = 8'd18;
    do_setup(8'h80, 8'h06, 16'h0100, 16'h0000, 16'd18, 7'h12);
    in_xact(8, 1'b1, 2'b00, 1'b1, 8'h60);
    out_xact(0, 1'b1, 2'b00, 1'b1);
    #1; chk("early_state_idle", state_dbg, ST_IDLE);

    // OUT data stage of 10 bytes: 8 + 2 with toggles 1, 0, then IN ZLP
    do_setup(8'h00, 8'h07, 16'h0000, 16'h0000, 16'd10, 7'h12);
    chk("dout_state", state_dbg, ST_DOUT);
    out_xact(8, 1'b1, 2'b00, 1'b1);
    #1; chk("dout_state_pkt1", state_dbg, ST_DOUT);
    out_xact(2, 1'b0, 2'b00, 1'b1);
    #1; chk("dout_state_status", state_dbg, ST_STATUS);
    in_xact(0, 1'b1, 2'b00, 1'b1, 8'h00);
    #1; chk("dout_state_idle", state_dbg, ST_IDLE);

    // Short SETUP (4 bytes) is dropped
    endpoint = 4'd0; setup = 1'b1; transaction_active = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      data_out = 8'(i); data_strobe = 1'b1;
      step();
    end
    data_strobe = 1'b0; transaction_active = 1'b0; success = 1'b1;
    step();
    success = 1'b0; setup = 1'b0; #1;
    chk("short_setup_state", state_dbg, ST_IDLE);
    chk("short_setup_req_valid", req_valid, 1'b0);

    // Stall, then recovery through a new SETUP
    resp_stall = 1'b1;
    do_setup(8'h80, 8'h06, 16'h0300, 16'h0000, 16'd10, 7'h12);
    chk("stall_state", state_dbg, ST_STALL);
    chk("stall_handshake", handshake, 2'b11);
    in_xact(0, 1'b1, 2'b11, 1'b1, 8'h00);
    out_xact(0, 1'b1, 2'b11, 1'b1);
    #1; chk("stall_state_kept", state_dbg, ST_STALL);
    resp_stall = 1'b0;
    do_setup(8'h00, 8'h09, 16'h0001, 16'h0000, 16'h0000, 7'h12);
    chk("cfg_state_status", state_dbg, ST_STATUS);
    in_xact(0, 1'b1, 2'b00, 1'b1, 8'h00);
    #1;
    chk("cfg_state_idle", state_dbg, ST_IDLE);
    chk("cfg_addr_kept", usb_address, 7'h12);

    // Foreign endpoint ignored, then bus reset in the middle of an IN packet
    resp_offset = 8'h70; resp_len = 8'd18;
    do_setup(8'h80, 8'h06, 16'h0100, 16'h0000, 16'd18, 7'h12);
    endpoint = 4'd2; direction_in = 1'b1; transaction_active = 1'b1;
    step(); #1;
    chk("ep2_valid", data_in_valid, 1'b0);
    transaction_active = 1'b0; success = 1'b1;
    step();
    success = 1'b0; #1;
    chk("ep2_state", state_dbg, ST_DIN);
    chk("ep2_toggle", data_toggle, 1'b1);
    endpoint = 4'd0; transaction_active = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      data_strobe = 1'b1;
      step();
    end
    usb_rst = 1'b1;
    step(); #1;
    chk("busrst_state", state_dbg, ST_IDLE);
    chk("busrst_data_in", data_in, 8'h00);
    chk("busrst_valid", data_in_valid, 1'b0);
    chk("busrst_toggle", data_toggle, 1'b0);
    chk("busrst_handshake", handshake, 2'b00);
    chk("busrst_address", usb_address, 7'h00);
    chk("busrst_req_valid", req_valid, 1'b0);
    chk("busrst_rom_addr", rom_addr, 8'h00);
    chk("busrst_bm", bm_request_type, 8'h00);
    chk("busrst_wvalue", w_value, 16'h0000);
    chk("busrst_wlength", w_length, 16'h0000);
    data_strobe = 1'b0; transaction_active = 1'b0; direction_in = 1'b0;
    step();
    usb_rst = 1'b0;
    step(); #1;
    chk("post_rst_state", state_dbg, ST_IDLE);
    resp_offset = 8'h50; resp_len = 8'd8;
    do_setup(8'h80, 8'h06, 16'h0100, 16'h0000, 16'd8, 7'h00);
    in_xact(8, 1'b1, 2'b00, 1'b1, 8'h50);
    #1; chk("post_rst_status", state_dbg, ST_STATUS);
    out_xact(0, 1'b1, 2'b00, 1'b1);
    #1; chk("post_rst_idle", state_dbg, ST_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_ep0_ctrl_sequencer.md
USB_EP0_CTRL_SEQUENCER -- requirements
Module: usb_ep0_ctrl_sequencer

Interface
REQ-001 Parameter MAX_PKT, default 8: endpoint-0 maximum packet size in bytes; legal values are 8, 16, 32 and 64.
REQ-002 clk  input  1: the single clock. All logic is clocked on its rising edge.
REQ-003 rst  input  1: synchronous, active-high reset.
REQ-004 usb_rst  input  1: bus reset from the USB core; while high it behaves the same as rst.
REQ-005 transaction_active, setup, direction_in, success, data_strobe  input  1 each: transaction status from the USB core.
REQ-006 endpoint  input  4: endpoint number of the current token.
REQ-007 data_out  input  8: byte received from the core; valid when data_strobe is high.
REQ-008 data_in  output  8 and data_in_valid  output  1: transmit byte to the core, and its valid flag.
REQ-009 data_toggle  output  1: DATA0/DATA1 selection.
REQ-010 handshake  output  2: handshake code; ack=00, nak=10, stall=11.
REQ-011 usb_address  output  7: device address in use.
REQ-012 rom_addr  output  8 and rom_data  input  8: descriptor ROM port; the ROM read is combinational.
REQ-013 req_valid  output  1: one-cycle pulse marking a decoded request.
REQ-014 bm_request_type, b_request  output  8 each, and w_value, w_index, w_length  output  16 each: fields of the decoded request.
REQ-015 resp_offset, resp_len  input  8 each, and resp_stall  input  1: the application's response to the request, sampled in the DECODE cycle.

Function
REQ-016 Start of a transaction SHALL be detected as a rising edge of transaction_active (registered one cycle); end of a transaction SHALL be detected as its falling edge.
REQ-017 Only transactions with endpoint==0 SHALL be acted on; other endpoints SHALL leave all state and outputs unchanged.
REQ-018 The state machine SHALL have the states IDLE, SETUP_RX, DECODE, DATA_IN, DATA_OUT, STATUS and STALL.
REQ-019 A SETUP token start SHALL take the block to SETUP_RX from any state:
- byte count cleared to 0
- data_toggle=0
- handshake=ack
REQ-020 In SETUP_RX, each data_strobe SHALL store data_out at setup byte[count] and increment count, saturating at 8; bytes are little-endian into the request fields.
REQ-021 At the end of the SETUP transaction, the block SHALL go to DECODE if success=1 and count==8; otherwise it SHALL go to IDLE.
REQ-022 DECODE SHALL last exactly one cycle:
- req_valid=1 and the request fields are stable for that cycle
- length = min(w_length, resp_len), compared at 16 bits, result 8 bits
REQ-023 Exit from DECODE, in priority order:
- resp_stall=1 -> STALL
- bm_request_type[7]=1 and length>0 -> DATA_IN
- bm_request_type[7]=0 and w_length>0 -> DATA_OUT
- otherwise -> STATUS (IN zero-length packet)
In every case data_toggle=1.
REQ-024 DATA_IN, on an IN transaction:
- rom_addr = resp_offset + sent + pkt_cnt, modulo 256
- data_in = rom_data
- data_in_valid=1 while sent+pkt_cnt < length and pkt_cnt < MAX_PKT
- each data_strobe increments pkt_cnt
REQ-025 DATA_IN, at transaction end with success=1:
- sent += pkt_cnt and data_toggle is inverted
- if sent==length or pkt_cnt<MAX_PKT -> STATUS
REQ-026 DATA_IN, at transaction end with success=0: pkt_cnt=0, while sent and data_toggle are kept, so the next IN retransmits the identical packet.
REQ-027 An OUT token start in DATA_IN (early status) SHALL move the block to STATUS and be handled as the status stage.
REQ-028 DATA_OUT: received bytes are counted and discarded; each successful OUT inverts data_toggle; when received >= w_length the block SHALL go to STATUS.
REQ-029 STATUS: the transaction in the direction opposite to the data stage SHALL use data_toggle=1; success returns to IDLE, failure stays in STATUS.
REQ-030 SET_ADDRESS (bm_request_type=0x00, b_request=0x05): usb_address SHALL take w_value[6:0] only on successful completion of the status stage, never earlier.
REQ-031 STALL: handshake=11 for every endpoint-0 non-SETUP transaction until the next SETUP token.
REQ-032 Outside transactions, data_in_valid SHALL be 0.

Reset
REQ-033 While rst or usb_rst is high, the block SHALL force:
- state=IDLE
- data_toggle=0, handshake=00, data_in=0x00, data_in_valid=0
- usb_address=0, req_valid=0, rom_addr=0
- all request fields 0
- sent, pkt_cnt and count all 0
REQ-034 A reset asserted mid-transfer SHALL abort the transfer, with no further strobes consumed.

Verification
REQ-035 Bench scenario: GET_DESCRIPTOR with wLength=18, resp_len=18, MAX_PKT=8 -> IN packets of 8, 8 and 2 bytes with toggles 1, 0, 1 from rom_addr resp_offset..+17, then an OUT ZLP with toggle 1 -> IDLE.
REQ-036 Bench scenario: SET_ADDRESS with w_value=0x0012 -> usb_address stays 0 through DECODE, becomes 0x12 on the cycle after the IN ZLP's success.
REQ-037 Bench scenario: wLength=64, resp_len=18 -> 18 bytes total, with the last packet short (2 bytes).
REQ-038 Bench scenario: IN packet completing with success=0 -> retry carries the same bytes with the same toggle.
REQ-039 Bench scenario: resp_stall=1 -> handshake=11 on following IN and OUT tokens; a new SETUP gives handshake=00 and count=0.
REQ-040 Bench scenario: usb_rst pulsed mid-DATA_IN -> every output at its reset value on the next cycle, and a subsequent SETUP is decoded normally.
